// File: rtl/id_ex_stage.sv
// Decode/issue stage with the ID/EX pipeline register: decodes the instruction, drives
// reg_file read addresses, inserts load-use bubbles. Define WB_BYPASS_EN to forward same-cycle writeback.
module id_ex_stage #(
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [31:0]            instr,
   input  logic                   flush,
   output logic [4:0]             readReg1,
   output logic [4:0]             readReg2,
   input  logic [31:0]            readData1,
   input  logic [31:0]            readData2,
   input  logic [4:0]             wb_writeReg,
   input  logic [31:0]            wb_writeData,
   input  logic                   wb_regWrite,
   output logic                   stall,
   output logic                   ex_valid,
   output logic [31:0]            ex_rs_val,
   output logic [31:0]            ex_rt_val,
   output logic [31:0]            ex_imm,
   output logic [4:0]             ex_rd,
   output logic                   ex_regWrite,
   output logic                   ex_memRead,
   output logic                   ex_memWrite,
   output logic                   ex_illegal,
   output logic [STALL_CNT_W-1:0] stall_count
);

   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_BUBBLE = 1'b1;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;

   localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

   logic [0:0]             r_state;
   logic                   r_exValid;
   logic [31:0]            r_exRsVal;
   logic [31:0]            r_exRtVal;
   logic [31:0]            r_exImm;
   logic [4:0]             r_exRd;
   logic                   r_exRegWrite;
   logic                   r_exMemRead;
   logic                   r_exMemWrite;
   logic                   r_exIllegal;
   logic [STALL_CNT_W-1:0] r_stallCount;

   logic [5:0]  w_opcode;
   logic [4:0]  w_rs;
   logic [4:0]  w_rt;
   logic [4:0]  w_dest;
   logic [31:0] w_imm;
   logic        w_legal;
   logic        w_decRegWrite;
   logic        w_memRead;
   logic        w_memWrite;
   logic        w_usesRt;
   logic        w_regWrite;
   logic [4:0]  w_rd;
   logic        w_hz;
   logic        w_stall;
   logic        w_loadValid;
   logic [31:0] w_rsVal;
   logic [31:0] w_rtVal;

   assign w_opcode = instr[31:26];
   assign w_rs     = instr[25:21];
   assign w_rt     = instr[20:16];
   assign readReg1 = w_rs;
   assign readReg2 = w_rt;

   always_comb begin
      w_dest        = 5'd0;
      w_imm         = 32'd0;
      w_legal       = 1'b1;
      w_decRegWrite = 1'b0;
      w_memRead     = 1'b0;
      w_memWrite    = 1'b0;
      w_usesRt      = 1'b0;
      case (w_opcode)
         OP_RTYPE: begin
            w_dest        = instr[15:11];
            w_decRegWrite = 1'b1;
            w_usesRt      = 1'b1;
         end
         OP_LW: begin
            w_dest        = w_rt;
            w_decRegWrite = 1'b1;
            w_memRead     = 1'b1;
            w_imm         = {{16{instr[15]}}, instr[15:0]};
         end
         OP_SW: begin
            w_memWrite = 1'b1;
            w_usesRt   = 1'b1;
            w_imm      = {{16{instr[15]}}, instr[15:0]};
         end
         OP_BEQ: begin
            w_usesRt = 1'b1;
            w_imm    = {{16{instr[15]}}, instr[15:0]};
         end
         OP_ADDI, OP_SLTI: begin
            w_dest        = w_rt;
            w_decRegWrite = 1'b1;
            w_imm         = {{16{instr[15]}}, instr[15:0]};
         end
         OP_ANDI, OP_ORI: begin
            w_dest        = w_rt;
            w_decRegWrite = 1'b1;
            w_imm         = {16'd0, instr[15:0]};
         end
         default: w_legal = 1'b0;
      endcase
   end

   // Writes to r0 are discarded, so they must never look like a producer downstream.
   assign w_regWrite  = w_decRegWrite && (w_dest != 5'd0);
   assign w_rd        = w_regWrite ? w_dest : 5'd0;
   assign w_loadValid = in_valid && w_legal;

   assign w_hz = in_valid && r_exValid && r_exMemRead && (r_exRd != 5'd0) &&
                 ((r_exRd == w_rs) || (w_usesRt && (r_exRd == w_rt)));
   assign w_stall = (r_state == ST_RUN) && w_hz && !flush && !reset;
   assign stall   = w_stall;

`ifdef WB_BYPASS_EN
   assign w_rsVal = (wb_regWrite && (wb_writeReg != 5'd0) && (wb_writeReg == w_rs)) ? wb_writeData : readData1;
   assign w_rtVal = (wb_regWrite && (wb_writeReg != 5'd0) && (wb_writeReg == w_rt)) ? wb_writeData : readData2;
`else
   logic w_unusedWb;
   assign w_unusedWb = ^{wb_regWrite, wb_writeReg, wb_writeData};
   assign w_rsVal    = readData1;
   assign w_rtVal    = readData2;
`endif

   // Flush beats the hazard bubble, and both clear every EX field so idle slots read as zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_RUN;
         r_exValid    <= 1'b0;
         r_exRsVal    <= 32'd0;
         r_exRtVal    <= 32'd0;
         r_exImm      <= 32'd0;
         r_exRd       <= 5'd0;
         r_exRegWrite <= 1'b0;
         r_exMemRead  <= 1'b0;
         r_exMemWrite <= 1'b0;
         r_exIllegal  <= 1'b0;
         r_stallCount <= '0;
      end else if (flush || w_stall || !w_loadValid) begin
         r_state      <= (w_stall) ? ST_BUBBLE : ST_RUN;
         r_exValid    <= 1'b0;
         r_exRsVal    <= 32'd0;
         r_exRtVal    <= 32'd0;
         r_exImm      <= 32'd0;
         r_exRd       <= 5'd0;
         r_exRegWrite <= 1'b0;
         r_exMemRead  <= 1'b0;
         r_exMemWrite <= 1'b0;
         r_exIllegal  <= !flush && !w_stall && in_valid && !w_legal;
         if (w_stall && (r_stallCount != '1)) begin
            r_stallCount <= r_stallCount + CNT_ONE;
         end
      end else begin
         r_state      <= ST_RUN;
         r_exValid    <= 1'b1;
         r_exRsVal    <= w_rsVal;
         r_exRtVal    <= w_rtVal;
         r_exImm      <= w_imm;
         r_exRd       <= w_rd;
         r_exRegWrite <= w_regWrite;
         r_exMemRead  <= w_memRead;
         r_exMemWrite <= w_memWrite;
         r_exIllegal  <= 1'b0;
      end
   end

   assign ex_valid    = r_exValid;
   assign ex_rs_val   = r_exRsVal;
   assign ex_rt_val   = r_exRtVal;
   assign ex_imm      = r_exImm;
   assign ex_rd       = r_exRd;
   assign ex_regWrite = r_exRegWrite;
   assign ex_memRead  = r_exMemRead;
   assign ex_memWrite = r_exMemWrite;
   assign ex_illegal  = r_exIllegal;
   assign stall_count = r_stallCount;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed cases with literal expectations,
// then randomized traffic compared every cycle against a behavioural EX-slot model.
module tb_id_ex_stage;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [31:0] instr;
   logic        flush;
   logic [4:0]  readReg1;
   logic [4:0]  readReg2;
   logic [31:0] readData1;
   logic [31:0] readData2;
   logic [4:0]  wb_writeReg;
   logic [31:0] wb_writeData;
   logic        wb_regWrite;
   logic        stall;
   logic        ex_valid;
   logic [31:0] ex_rs_val;
   logic [31:0] ex_rt_val;
   logic [31:0] ex_imm;
   logic [4:0]  ex_rd;
   logic        ex_regWrite;
   logic        ex_memRead;
   logic        ex_memWrite;
   logic        ex_illegal;
   logic [15:0] stall_count;

   int errors = 0;
   int checks = 0;
   bit cmpEn  = 0;

   id_ex_stage #(.STALL_CNT_W(16)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr), .flush(flush),
      .readReg1(readReg1), .readReg2(readReg2), .readData1(readData1), .readData2(readData2),
      .wb_writeReg(wb_writeReg), .wb_writeData(wb_writeData), .wb_regWrite(wb_regWrite),
      .stall(stall), .ex_valid(ex_valid), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val),
      .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
      .ex_memWrite(ex_memWrite), .ex_illegal(ex_illegal), .stall_count(stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        legal;
      logic        regWrite;
      logic        memRead;
      logic        memWrite;
      logic        usesRt;
      logic [4:0]  dest;
      logic [31:0] imm;
   } dec_t;

   // Expected contents of the EX slot, advanced at every rising edge.
   logic        mValid, mRw, mMr, mMw, mIll, mLastStall;
   logic [31:0] mRs, mRt, mImm;
   logic [4:0]  mRd;
   int          mCount;

   function automatic dec_t decodeInstr(input logic [31:0] ins);
      dec_t d;
      logic [31:0] sx;
      sx = {{16{ins[15]}}, ins[15:0]};
      d = '0;
      d.legal = 1'b1;
      case (ins[31:26])
         6'h00: begin d.dest = ins[15:11]; d.regWrite = 1; d.usesRt = 1; end
         6'h23: begin d.dest = ins[20:16]; d.regWrite = 1; d.memRead = 1; d.imm = sx; end
         6'h2B: begin d.memWrite = 1; d.usesRt = 1; d.imm = sx; end
         6'h04: begin d.usesRt = 1; d.imm = sx; end
         6'h08, 6'h0A: begin d.dest = ins[20:16]; d.regWrite = 1; d.imm = sx; end
         6'h0C, 6'h0D: begin d.dest = ins[20:16]; d.regWrite = 1; d.imm = {16'd0, ins[15:0]}; end
         default: d.legal = 1'b0;
      endcase
      if (d.dest == 5'd0) d.regWrite = 1'b0;
      if (!d.regWrite) d.dest = 5'd0;
      return d;
   endfunction

   function automatic logic modelStall();
      dec_t d;
      d = decodeInstr(instr);
      return in_valid && mValid && mMr && (mRd != 0) && !flush && !reset &&
             ((mRd == instr[25:21]) || (d.usesRt && (mRd == instr[20:16])));
   endfunction

   function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf);
`ifdef WB_BYPASS_EN
      if (wb_regWrite && r != 0 && wb_writeReg == r) return wb_writeData;
`endif
      return rf;
   endfunction

   always @(posedge clk or posedge reset) begin
      dec_t d;
      logic st;
      if (reset) begin
         {mValid, mRw, mMr, mMw, mIll, mLastStall} = '0;
         {mRs, mRt, mImm, mRd} = '0;
         mCount = 0;
      end else begin
         st = modelStall();
         d  = decodeInstr(instr);
         {mValid, mRw, mMr, mMw, mIll} = '0;
         {mRs, mRt, mImm, mRd} = '0;
         if (st) begin
            if (mCount < 65535) mCount++;
         end else if (!flush && in_valid) begin
            if (d.legal) begin
               mValid = 1; mRw = d.regWrite; mMr = d.memRead; mMw = d.memWrite;
               mImm = d.imm; mRd = d.dest;
               mRs = operand(instr[25:21], readData1);
               mRt = operand(instr[20:16], readData2);
            end else begin
               mIll = 1;
            end
         end
         mLastStall = st;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmpEn && !reset) begin
         checkOutput("stall", stall, modelStall());
         checkOutput("readReg1", readReg1, instr[25:21]);
         checkOutput("readReg2", readReg2, instr[20:16]);
         checkOutput("ex_valid", ex_valid, mValid);
         checkOutput("ex_rs_val", ex_rs_val, mRs);
         checkOutput("ex_rt_val", ex_rt_val, mRt);
         checkOutput("ex_imm", ex_imm, mImm);
         checkOutput("ex_rd", ex_rd, mRd);
         checkOutput("ex_regWrite", ex_regWrite, mRw);
         checkOutput("ex_memRead", ex_memRead, mMr);
         checkOutput("ex_memWrite", ex_memWrite, mMw);
         checkOutput("ex_illegal", ex_illegal, mIll);
         checkOutput("stall_count", stall_count, mCount);
      end
   end

   task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] d1,
                                input logic [31:0] d2, input logic fl, input logic wrw,
                                input logic [4:0] wreg, input logic [31:0] wdata);
      @(posedge clk);
      #1;
      in_valid = v; instr = ins; readData1 = d1; readData2 = d2; flush = fl;
      wb_regWrite = wrw; wb_writeReg = wreg; wb_writeData = wdata;
      @(negedge clk);
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
   endtask

   function automatic logic [31:0] randInstr();
      logic [5:0] ops [10];
      logic [5:0] op;
      ops = '{6'h00, 6'h23, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h3F};
      op = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 19) == 0) op = 6'($urandom);
      return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 11'($urandom)};
   endfunction

   localparam logic [31:0] ADD3_1_2  = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
   localparam logic [31:0] LW5_M4_1  = {6'h23, 5'd1, 5'd5, 16'hFFFC};
   localparam logic [31:0] ADD6_5_2  = {6'h00, 5'd5, 5'd2, 5'd6, 5'd0, 6'h20};
   localparam logic [31:0] LW0_0_1   = {6'h23, 5'd1, 5'd0, 16'h0000};
   localparam logic [31:0] ADD6_0_2  = {6'h00, 5'd0, 5'd2, 5'd6, 5'd0, 6'h20};
   localparam logic [31:0] ILLEGAL3F = {6'h3F, 26'd0};

   initial begin
      logic [31:0] curInstr;
      logic        curValid;
      reset = 1'b1; in_valid = 0; instr = 0; flush = 0; readData1 = 0; readData2 = 0;
      wb_regWrite = 0; wb_writeReg = 0; wb_writeData = 0;
      #1;
      checkOutput("reset ex_valid", ex_valid, 0);
      checkOutput("reset stall", stall, 0);
      checkOutput("reset stall_count", stall_count, 0);
      @(negedge clk);
      reset = 1'b0;
      cmpEn = 1'b1;

      applyStimulus(1, ADD3_1_2, 32'd10, 32'd20, 0, 0, 5'd0, 32'd0);
      idleCycle();
      checkOutput("add ex_valid", ex_valid, 1);
      checkOutput("add ex_rs_val", ex_rs_val, 32'd10);
      checkOutput("add ex_rt_val", ex_rt_val, 32'd20);
      checkOutput("add ex_rd", ex_rd, 5'd3);
      checkOutput("add ex_regWrite", ex_regWrite, 1);

      applyStimulus(1, ADD3_1_2, 32'd10, 32'd20, 0, 1, 5'd1, 32'd99);
      idleCycle();
`ifdef WB_BYPASS_EN
      checkOutput("bypass ex_rs_val", ex_rs_val, 32'd99);
`else
      checkOutput("no-bypass ex_rs_val", ex_rs_val, 32'd10);
`endif

      applyStimulus(1, LW5_M4_1, 32'd100, 32'd0, 0, 0, 5'd0, 32'd0);
      applyStimulus(1, ADD6_5_2, 32'd7, 32'd8, 0, 0, 5'd0, 32'd0);
      checkOutput("lw ex_imm", ex_imm, 32'hFFFF_FFFC);
      checkOutput("lw ex_rd", ex_rd, 5'd5);
      checkOutput("load-use stall", stall, 1);
      applyStimulus(1, ADD6_5_2, 32'd7, 32'd8, 0, 0, 5'd0, 32'd0);
      checkOutput("bubble stall", stall, 0);
      checkOutput("bubble ex_valid", ex_valid, 0);
      checkOutput("bubble stall_count", stall_count, 1);
      idleCycle();
      checkOutput("post-bubble ex_valid", ex_valid, 1);
      checkOutput("post-bubble ex_rd", ex_rd, 5'd6);

      applyStimulus(1, LW0_0_1, 32'd3, 32'd0, 0, 0, 5'd0, 32'd0);
      applyStimulus(1, ADD6_0_2, 32'd0, 32'd4, 0, 0, 5'd0, 32'd0);
      checkOutput("lw r0 stall", stall, 0);
      checkOutput("lw r0 ex_regWrite", ex_regWrite, 0);
      checkOutput("lw r0 ex_memRead", ex_memRead, 1);

      applyStimulus(1, ILLEGAL3F, 32'd0, 32'd0, 0, 0, 5'd0, 32'd0);
      idleCycle();
      checkOutput("illegal ex_valid", ex_valid, 0);
      checkOutput("illegal ex_illegal", ex_illegal, 1);
      idleCycle();
      checkOutput("illegal pulse end", ex_illegal, 0);

      applyStimulus(1, LW5_M4_1, 32'd100, 32'd0, 0, 0, 5'd0, 32'd0);
      applyStimulus(1, ADD6_5_2, 32'd7, 32'd8, 1, 0, 5'd0, 32'd0);
      checkOutput("flush stall", stall, 0);
      idleCycle();
      checkOutput("flush ex_valid", ex_valid, 0);
      checkOutput("flush ex_regWrite", ex_regWrite, 0);
      checkOutput("flush stall_count", stall_count, 1);

      // Asynchronous reset landing mid-cycle, first with a live EX slot, then in BUBBLE.
      applyStimulus(1, ADD3_1_2, 32'd10, 32'd20, 0, 0, 5'd0, 32'd0);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      checkOutput("async reset ex_valid", ex_valid, 0);
      checkOutput("async reset ex_rs_val", ex_rs_val, 0);
      checkOutput("async reset ex_regWrite", ex_regWrite, 0);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(1, LW5_M4_1, 32'd100, 32'd0, 0, 0, 5'd0, 32'd0);
      applyStimulus(1, ADD6_5_2, 32'd7, 32'd8, 0, 0, 5'd0, 32'd0);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      checkOutput("bubble reset stall", stall, 0);
      checkOutput("bubble reset stall_count", stall_count, 0);
      checkOutput("bubble reset ex_memRead", ex_memRead, 0);
      @(negedge clk);
      reset = 1'b0;

      curInstr = randInstr();
      curValid = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (!mLastStall) begin
            curInstr = randInstr();
            curValid = ($urandom_range(0, 7) != 0);
         end
         applyStimulus(curValid, curInstr, $urandom, $urandom, ($urandom_range(0, 15) == 0),
                       $urandom_range(0, 1), 5'($urandom_range(0, 3)), $urandom);
      end

      cmpEn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode/issue stage and ID/EX pipeline register sitting directly downstream of reg_file.
- Drives reg_file read addresses from the incoming instruction and registers the returned operands into EX.
- Decodes control and destination fields, detects load-use hazards and inserts bubbles, and optionally bypasses the same-cycle writeback value.

Parameters:
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  instr is a valid instruction from IF/ID.
- instr  in  32  MIPS instruction word.
- flush  in  1  kill the instruction being loaded into EX (branch redirect).
- readReg1  out  5  to reg_file, = instr[25:21] (rs), combinational.
- readReg2  out  5  to reg_file, = instr[20:16] (rt), combinational.
- readData1  in  32  from reg_file, rs value.
- readData2  in  32  from reg_file, rt value.
- wb_writeReg  in  5  writeback destination (same signal as reg_file writeReg).
- wb_writeData  in  32  writeback data.
- wb_regWrite  in  1  writeback enable.
- stall  out  1  combinational; holds IF/ID (instr must be re-presented next cycle).
- ex_valid  out  1  EX holds a real instruction.
- ex_rs_val  out  32  registered rs operand.
- ex_rt_val  out  32  registered rt operand.
- ex_imm  out  32  registered extended immediate.
- ex_rd  out  5  registered destination register.
- ex_regWrite  out  1  registered write enable.
- ex_memRead  out  1  registered load flag.
- ex_memWrite  out  1  registered store flag.
- ex_illegal  out  1  pulses 1 cycle when an undecodable opcode is dropped.
- stall_count  out  STALL_CNT_W  saturating count of bubble cycles inserted.

Behaviour:
- Reset (async): all ex_* outputs, stall_count = 0; FSM = RUN. stall is combinational and reads 0 while reset is held.
- Decode on opcode instr[31:26]:
  - 0x00 R-type: dest rd = instr[15:11], regWrite=1, uses rt.
  - 0x23 lw: dest rt, regWrite=1, memRead=1, uses rs only.
  - 0x2B sw: regWrite=0, memWrite=1, uses rt.
  - 0x04 beq: regWrite=0, uses rt.
  - 0x08 addi, 0x0A slti: dest rt, regWrite=1, sign-extend imm.
  - 0x0C andi, 0x0D ori: dest rt, regWrite=1, zero-extend imm.
  - Any other opcode: illegal. Loaded as a bubble (ex_valid=0), ex_illegal=1 for one cycle.
- Destination 0 rule: if dest==0, ex_regWrite is forced 0; r0 never creates a hazard or bypass match.
- Hazard: hz = in_valid & ex_valid & ex_memRead & ex_rd!=0 & (ex_rd==rs | (uses_rt & ex_rd==rt)).
- FSM:
  - RUN: if hz & !flush then stall=1; next edge loads a bubble (ex_valid=0, control fields 0), stall_count+1 (saturating at all-ones), go BUBBLE. Otherwise load the decoded instruction (ex_valid=in_valid), stay RUN.
  - BUBBLE: stall=0; load the decoded instruction normally; go RUN.
- Flush has priority over everything: next edge ex_valid=0, all control fields 0, ex_illegal=0, stall=0, FSM=RUN. stall_count does not increment.
- in_valid=0 loads a bubble with no stall.
- Latency: instr at edge N appears on ex_* after edge N+1; after edge N+2 when a load-use bubble is inserted.
- Operands are taken from readData1/2 (or the bypass) at the capture edge.
- ex_imm and ex_rd are don't-care when ex_valid=0 but must be deterministic (0).

Optional Feature:
- WB_BYPASS_EN defined:
  - If wb_regWrite & wb_writeReg!=0 & wb_writeReg==rs, ex_rs_val captures wb_writeData instead of readData1; same rule for rt → ex_rt_val.
  - This covers the reg_file write that lands on the same edge as the read.
- WB_BYPASS_EN undefined: operands are always readData1/readData2 unmodified.

Test Plan:
- Reset while ex_valid=1, mid-BUBBLE → all ex_* =0, stall=0, stall_count=0, FSM RUN immediately (asynchronous).
- R-type add $3,$1,$2 with readData1=10, readData2=20 → next cycle ex_valid=1, ex_rs_val=10, ex_rt_val=20, ex_rd=3, ex_regWrite=1.
- lw $5,-4($1) then add $6,$5,$2 → add cycle: stall=1; next edge bubble; stall_count=1. Following edge add enters EX with ex_rd=6.
- lw $0,0($1) then add $6,$0,$2 → no stall; ex_regWrite=0 for the lw.
- Opcode 0x3F → ex_valid=0, ex_illegal=1 for one cycle. flush asserted during a hazard → stall=0, ex_valid=0, stall_count unchanged.
- WB_BYPASS_EN: wb_regWrite=1, wb_writeReg=1, wb_writeData=99, readData1=10, instr rs=1 → ex_rs_val=99. Macro off → 10.
